// File: rtl/updown_counter_ctrl.sv
// Up/down counter with runtime bounds, variable step and saturate/wrap/one-shot
// limit handling. Produces registered one-cycle ovf/unf pulses at limit events.
module updown_counter_ctrl #(
    parameter int unsigned             WIDTH     = 8,
    parameter int unsigned             STEP_W    = 4,
    parameter logic        [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              at_min,
    output logic              at_max,
    output logic              ovf,
    output logic              unf,
    output logic              halted,
    output logic              cfg_err
);

    localparam logic [1:0] MODE_WRAP    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             unf_next;
    logic             halted_next;

    // One extra bit keeps the carry out of count + step.
    logic        [WIDTH:0] up_sum;
    // Signed with one extra bit so a borrow below zero shows as negative.
    logic signed [WIDTH:0] down_diff;
    logic signed [WIDTH:0] min_ext;

    // Clamp a load value into [lo, hi]; bypassed when the bounds are inverted.
    function automatic logic [WIDTH-1:0] clamp_load(
        input logic [WIDTH-1:0] value,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi,
        input logic             bad_cfg
    );
        logic [WIDTH-1:0] result;
        result = value;
        if (!bad_cfg) begin
            if (value < lo)
                result = lo;
            else if (value > hi)
                result = hi;
        end
        return result;
    endfunction

    // Target count after crossing a limit: wrap lands on the opposite bound,
    // every other mode (including reserved) stays on the crossed bound.
    function automatic logic [WIDTH-1:0] limit_target(
        input logic [1:0]       lim_mode,
        input logic [WIDTH-1:0] crossed,
        input logic [WIDTH-1:0] opposite
    );
        return (lim_mode == MODE_WRAP) ? opposite : crossed;
    endfunction

    assign cfg_err = (min_val > max_val);
    assign at_min  = (count == min_val);
    assign at_max  = (count == max_val);

    assign up_sum    = {1'b0, count} + {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign down_diff = $signed({1'b0, count}) - $signed({{(WIDTH + 1 - STEP_W){1'b0}}, step});
    assign min_ext   = $signed({1'b0, min_val});

    // Next-state selection: load beats counting; counting needs a clean config.
    always_comb begin
        count_next  = count;
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        halted_next = halted;

        if (load) begin
            count_next  = clamp_load(load_value, min_val, max_val, cfg_err);
            halted_next = 1'b0;
        end else if (en && !cfg_err && !halted && (step != '0)) begin
            if (up && !down) begin
                if (up_sum > {1'b0, max_val}) begin
                    count_next = limit_target(mode, max_val, min_val);
                    ovf_next   = 1'b1;
                    if (mode == MODE_ONESHOT)
                        halted_next = 1'b1;
                end else begin
                    count_next = up_sum[WIDTH-1:0];
                end
            end else if (down && !up) begin
                if (down_diff < min_ext) begin
                    count_next = limit_target(mode, min_val, max_val);
                    unf_next   = 1'b1;
                    if (mode == MODE_ONESHOT)
                        halted_next = 1'b1;
                end else begin
                    count_next = down_diff[WIDTH-1:0];
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count  <= RESET_VAL;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            halted <= 1'b0;
        end else begin
            count  <= count_next;
            ovf    <= ovf_next;
            unf    <= unf_next;
            halted <= halted_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed self-checking bench for updown_counter_ctrl with hand-computed
// expected values.
module tb_updown_counter_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       load;
    logic [7:0] load_value;
    logic       up;
    logic       down;
    logic [3:0] step;
    logic [7:0] min_val;
    logic [7:0] max_val;
    logic [1:0] mode;
    logic [7:0] count;
    logic       at_min;
    logic       at_max;
    logic       ovf;
    logic       unf;
    logic       halted;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;

    updown_counter_ctrl #(
        .WIDTH    (8),
        .STEP_W   (4),
        .RESET_VAL(8'd0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .load      (load),
        .load_value(load_value),
        .up        (up),
        .down      (down),
        .step      (step),
        .min_val   (min_val),
        .max_val   (max_val),
        .mode      (mode),
        .count     (count),
        .at_min    (at_min),
        .at_max    (at_max),
        .ovf       (ovf),
        .unf       (unf),
        .halted    (halted),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] c, input logic o,
                               input logic u, input logic h);
        check({tag, ".count"},  count,  c);
        check({tag, ".ovf"},    ovf,    o);
        check({tag, ".unf"},    unf,    u);
        check({tag, ".halted"}, halted, h);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; load = 1'b0; load_value = '0; up = 1'b0; down = 1'b0;
        step = '0; min_val = '0; max_val = '0; mode = 2'b00;

        // Reset and clamped loads
        tick();
        check_state("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        min_val = 8'd10; max_val = 8'd150;
        do_load(8'd200);
        check("load_hi.count", count, 8'd150);
        check("load_hi.at_max", at_max, 1'b1);
        do_load(8'd5);
        check("load_lo.count", count, 8'd10);
        check("load_lo.at_min", at_min, 1'b1);

        // Saturate up with repeated ovf at the limit
        min_val = 8'd0; max_val = 8'd255;
        do_load(8'd250);
        en = 1'b1; up = 1'b1; step = 4'd3;
        tick(); check_state("sat1", 8'd253, 1'b0, 1'b0, 1'b0);
        tick(); check_state("sat2", 8'd255, 1'b1, 1'b0, 1'b0);
        check("sat2.at_max", at_max, 1'b1);
        tick(); check_state("sat3", 8'd255, 1'b1, 1'b0, 1'b0);
        up = 1'b0;
        tick(); check_state("sat4", 8'd255, 1'b0, 1'b0, 1'b0);

        // Saturate down
        min_val = 8'd10;
        do_load(8'd12);
        down = 1'b1; step = 4'd5;
        tick(); check_state("satdn", 8'd10, 1'b0, 1'b1, 1'b0);
        down = 1'b0;

        // Wrap down
        mode = 2'b01; min_val = 8'd20; max_val = 8'd100;
        do_load(8'd22);
        down = 1'b1; step = 4'd4;
        tick(); check_state("wrap1", 8'd100, 1'b0, 1'b1, 1'b0);
        check("wrap1.at_max", at_max, 1'b1);
        tick(); check_state("wrap2", 8'd96, 1'b0, 1'b0, 1'b0);
        down = 1'b0;

        // One-shot
        mode = 2'b10; min_val = 8'd0; max_val = 8'd9;
        do_load(8'd8);
        up = 1'b1; step = 4'd2;
        tick(); check_state("os1", 8'd9, 1'b1, 1'b0, 1'b1);
        tick(); check_state("os2", 8'd9, 1'b0, 1'b0, 1'b1);
        up = 1'b0; down = 1'b1;
        tick(); check_state("os3", 8'd9, 1'b0, 1'b0, 1'b1);
        mode = 2'b00;
        tick(); check_state("os4", 8'd9, 1'b0, 1'b0, 1'b1);
        down = 1'b0;
        do_load(8'd3);
        check_state("os_load", 8'd3, 1'b0, 1'b0, 1'b0);

        // Hold cases
        max_val = 8'd255;
        up = 1'b1; down = 1'b1; step = 4'd2;
        tick(); check_state("hold_both", 8'd3, 1'b0, 1'b0, 1'b0);
        down = 1'b0; step = 4'd0;
        tick(); check_state("hold_step0", 8'd3, 1'b0, 1'b0, 1'b0);
        step = 4'd2; en = 1'b0;
        tick(); check_state("hold_en0", 8'd3, 1'b0, 1'b0, 1'b0);
        en = 1'b1; min_val = 8'd50; max_val = 8'd40;
        #1; check("cfg_err", cfg_err, 1'b1);
        tick(); check_state("hold_cfg", 8'd3, 1'b0, 1'b0, 1'b0);
        up = 1'b0;
        do_load(8'd200);
        check("load_cfg_err.count", count, 8'd200);

        // Count above max after bounds change
        min_val = 8'd0; max_val = 8'd100;
        #1; check("cfg_ok", cfg_err, 1'b0);
        up = 1'b1; step = 4'd1;
        tick(); check_state("above_max_up", 8'd100, 1'b1, 1'b0, 1'b0);
        up = 1'b0;
        max_val = 8'd50;
        down = 1'b1; step = 4'd3;
        tick(); check_state("above_max_dn", 8'd97, 1'b0, 1'b0, 1'b0);
        down = 1'b0;

        // min == max
        min_val = 8'd5; max_val = 8'd5;
        do_load(8'd5);
        up = 1'b1; step = 4'd1;
        tick(); check_state("eq_up", 8'd5, 1'b1, 1'b0, 1'b0);
        up = 1'b0; down = 1'b1;
        tick(); check_state("eq_dn", 8'd5, 1'b0, 1'b1, 1'b0);
        down = 1'b0;

        // Reset mid-count
        min_val = 8'd0; max_val = 8'd255;
        do_load(8'd100);
        up = 1'b1; step = 4'd1;
        tick(); check("run1.count", count, 8'd101);
        tick(); check("run2.count", count, 8'd102);
        rstn = 1'b0;
        tick(); check_state("mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        tick(); check("resume.count", count, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
